// File: rtl/line_bank_buffer.sv
// Ring-ordered N-bank line/frame buffer: a writer fills and commits banks, a reader scans and releases them.
// Bank ownership moves by commit/release pulses; protocol violations raise sticky error flags.
module line_bank_buffer #(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 120,
    parameter int BANKS        = 2,
    parameter int READ_LATENCY = 1,
    parameter int HOLD_LAST    = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_release,
    output logic                  rd_ready,
    output logic [CW-1:0]         filled,
    output logic                  wr_err,
    output logic                  rd_err,
    input  logic                  err_clr
);

    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int PW = $clog2(BANKS * DEPTH);
    localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0]  BANKS_C   = CW'(BANKS);
    localparam logic [BW-1:0]  LAST_BANK = BW'(BANKS - 1);

    logic [BW-1:0]         wr_ptr;
    logic [BW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [BANKS*DEPTH];

    logic wr_ok, commit_ok, rd_ok, rel_hold, rel_ok;
    logic wr_bad, rd_bad;

    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] rd_data_p0;

    function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
        return (p == LAST_BANK) ? '0 : p + BW'(1);
    endfunction

    function automatic logic [PW-1:0] phys_addr(input logic [BW-1:0] bank, input logic [AW-1:0] addr);
        return PW'(int'(bank) * DEPTH + int'(addr));
    endfunction

    assign wr_ready = (filled < BANKS_C);
    assign rd_ready = (filled != '0);

    assign wr_ok     = wr_en & wr_ready & ({1'b0, wr_addr} < DEPTH_C);
    assign commit_ok = wr_commit & wr_ready;
    assign rd_ok     = rd_en & rd_ready & ({1'b0, rd_addr} < DEPTH_C);
    // With HOLD_LAST the only committed bank stays with the reader unless a new one arrives this cycle.
    assign rel_hold  = (HOLD_LAST != 0) && (filled == CW'(1)) && !commit_ok;
    assign rel_ok    = rd_release & rd_ready & !rel_hold;

    assign wr_bad = (wr_en & !wr_ok) | (wr_commit & !wr_ready);
    assign rd_bad = (rd_en & !rd_ok) | (rd_release & !rd_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            filled <= '0;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            if (commit_ok) wr_ptr <= next_ptr(wr_ptr);
            if (rel_ok)    rd_ptr <= next_ptr(rd_ptr);
            filled <= filled + CW'(commit_ok) - CW'(rel_ok);
            if (wr_bad)       wr_err <= 1'b1;
            else if (err_clr) wr_err <= 1'b0;
            if (rd_bad)       rd_err <= 1'b1;
            else if (err_clr) rd_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[phys_addr(wr_ptr, wr_addr)] <= wr_data;
    end

    // Stage p0: memory read using the bank owned by the reader in the rd_en cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            rd_data_p0 <= '0;
        end else begin
            vld_p0 <= rd_ok;
            if (rd_ok) rd_data_p0 <= mem[phys_addr(rd_ptr, rd_addr)];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld_p1;
            logic [DATA_WIDTH-1:0] rd_data_p1;

            // Stage p1: optional output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1     <= 1'b0;
                    rd_data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) rd_data_p1 <= rd_data_p0;
                end
            end

            assign rd_data  = rd_data_p1;
            assign rd_valid = vld_p1;
        end else begin : g_lat1
            assign rd_data  = rd_data_p0;
            assign rd_valid = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_line_bank_buffer.sv
// Directed bench: two instances share stimulus (A: 3 banks, latency 1, hold-last; B: 2 banks, latency 2, no hold).
module tb_line_bank_buffer;

    localparam int DW = 128;
    localparam int AW = 7;

    logic          clk;
    logic          rst_n;
    logic          wr_en, wr_commit, rd_en, rd_release, err_clr;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    logic          a_wr_ready, a_rd_valid, a_rd_ready, a_wr_err, a_rd_err;
    logic [DW-1:0] a_rd_data;
    logic [1:0]    a_filled;
    logic          b_wr_ready, b_rd_valid, b_rd_ready, b_wr_err, b_rd_err;
    logic [DW-1:0] b_rd_data;
    logic [1:0]    b_filled;

    int checks = 0;
    int errors = 0;

    line_bank_buffer #(.DATA_WIDTH(DW), .DEPTH(120), .BANKS(3), .READ_LATENCY(1), .HOLD_LAST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(a_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_release(rd_release), .rd_ready(a_rd_ready),
        .filled(a_filled), .wr_err(a_wr_err), .rd_err(a_rd_err), .err_clr(err_clr)
    );

    line_bank_buffer #(.DATA_WIDTH(DW), .DEPTH(120), .BANKS(2), .READ_LATENCY(2), .HOLD_LAST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(b_wr_ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_release(rd_release), .rd_ready(b_rd_ready),
        .filled(b_filled), .wr_err(b_wr_err), .rd_err(b_rd_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          vld;
        logic [DW-1:0] data;
    } rvec_t;

    rvec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic write_words(input int n, input int off);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = DW'(i + off);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic pulse_release();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Single read: A answers after one edge, B after two.
    task automatic read_both(input string nm, input logic [AW-1:0] addr, input int av, input int ad,
                             input int bv, input int bd);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en = 1'b0;
        chk({nm, " a_vld"}, 32'(a_rd_valid), av);
        chkd({nm, " a_data"}, a_rd_data, DW'(ad));
        chk({nm, " b_vld_early"}, 32'(b_rd_valid), 0);
        tick();
        chk({nm, " b_vld"}, 32'(b_rd_valid), bv);
        chkd({nm, " b_data"}, b_rd_data, DW'(bd));
        chk({nm, " a_vld_pulse"}, 32'(a_rd_valid), 0);
    endtask

    initial begin
        tbl[0] = '{addr: 7'd0,   vld: 1'b1, data: DW'(0)};
        tbl[1] = '{addr: 7'd5,   vld: 1'b1, data: DW'(5)};
        tbl[2] = '{addr: 7'd64,  vld: 1'b1, data: DW'(64)};
        tbl[3] = '{addr: 7'd119, vld: 1'b1, data: DW'(119)};
        tbl[4] = '{addr: 7'd120, vld: 1'b0, data: DW'(119)};

        rst_n = 1'b0; wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; err_clr = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        tick(); tick();
        chk("rst a_filled", 32'(a_filled), 0);
        chk("rst a_wr_ready", 32'(a_wr_ready), 1);
        chk("rst a_rd_ready", 32'(a_rd_ready), 0);
        chk("rst a_rd_valid", 32'(a_rd_valid), 0);
        chkd("rst a_rd_data", a_rd_data, '0);
        chk("rst b_rd_valid", 32'(b_rd_valid), 0);
        chkd("rst b_rd_data", b_rd_data, '0);
        chk("rst errs", 32'({a_wr_err, a_rd_err, b_wr_err, b_rd_err}), 0);
        rst_n = 1'b1;
        tick();

        // Fill bank 0 fully; nothing is readable until the commit lands
        write_words(120, 0);
        chk("pre-commit a_rd_ready", 32'(a_rd_ready), 0);
        pulse_commit();
        chk("commit a_filled", 32'(a_filled), 1);
        chk("commit a_rd_ready", 32'(a_rd_ready), 1);
        chk("commit b_filled", 32'(b_filled), 1);
        chk("commit b_rd_ready", 32'(b_rd_ready), 1);

        for (int i = 0; i < 5; i++)
            read_both($sformatf("tbl%0d", i), tbl[i].addr, 32'(tbl[i].vld), int'(tbl[i].data),
                      32'(tbl[i].vld), int'(tbl[i].data));
        chk("oob rd a_rd_err", 32'(a_rd_err), 1);
        chk("oob rd b_rd_err", 32'(b_rd_err), 1);
        clear_errs();
        chk("clr a_rd_err", 32'(a_rd_err), 0);

        // Back-to-back reads
        rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rd_addr = AW'(i);
            tick();
            chk("b2b a_vld", 32'(a_rd_valid), 1);
            chkd("b2b a_data", a_rd_data, DW'(i));
            if (i > 1) chkd("b2b b_data", b_rd_data, DW'(i - 1));
        end
        rd_en = 1'b0;
        tick();
        chk("b2b a_vld_end", 32'(a_rd_valid), 0);
        chkd("b2b a_hold", a_rd_data, DW'(3));
        chkd("b2b b_last", b_rd_data, DW'(3));

        // Bank 1; B becomes full
        write_words(8, 256);
        pulse_commit();
        chk("bank1 a_filled", 32'(a_filled), 2);
        chk("bank1 b_filled", 32'(b_filled), 2);
        chk("bank1 b_wr_ready", 32'(b_wr_ready), 0);
        chk("bank1 b_wr_err", 32'(b_wr_err), 0);

        // Bank 2 on A; B rejects the writes and the commit
        write_words(8, 512);
        pulse_commit();
        chk("bank2 a_filled", 32'(a_filled), 3);
        chk("bank2 a_wr_ready", 32'(a_wr_ready), 0);
        chk("bank2 a_wr_err", 32'(a_wr_err), 0);
        chk("bank2 b_filled", 32'(b_filled), 2);
        chk("bank2 b_wr_err", 32'(b_wr_err), 1);
        write_words(1, 999);
        pulse_commit();
        chk("full a_filled", 32'(a_filled), 3);
        chk("full a_wr_err", 32'(a_wr_err), 1);
        clear_errs();
        chk("clr a_wr_err", 32'(a_wr_err), 0);
        chk("clr b_wr_err", 32'(b_wr_err), 0);

        // Commit while full plus release: commit rejected, release accepted
        wr_commit = 1'b1; rd_release = 1'b1;
        tick();
        wr_commit = 1'b0; rd_release = 1'b0;
        chk("fullcr a_filled", 32'(a_filled), 2);
        chk("fullcr a_wr_err", 32'(a_wr_err), 1);
        chk("fullcr b_filled", 32'(b_filled), 1);
        clear_errs();
        read_both("bank1", 7'd3, 1, 259, 1, 259);

        // A down to one bank; B empties (no hold)
        pulse_release();
        chk("rel a_filled", 32'(a_filled), 1);
        chk("rel b_filled", 32'(b_filled), 0);
        chk("rel b_rd_ready", 32'(b_rd_ready), 0);
        read_both("bank2", 7'd3, 1, 515, 0, 259);
        chk("empty rd b_rd_err", 32'(b_rd_err), 1);
        clear_errs();

        // Hold-last on A: release ignored silently
        pulse_release();
        chk("hold a_filled", 32'(a_filled), 1);
        chk("hold a_rd_err", 32'(a_rd_err), 0);
        chk("hold a_rd_ready", 32'(a_rd_ready), 1);
        chk("empty rel b_rd_err", 32'(b_rd_err), 1);
        read_both("hold reread", 7'd4, 1, 516, 0, 259);
        clear_errs();

        // Same-cycle commit + release at filled==1
        write_words(8, 768);
        wr_commit = 1'b1; rd_release = 1'b1;
        tick();
        wr_commit = 1'b0; rd_release = 1'b0;
        chk("cr a_filled", 32'(a_filled), 1);
        chk("cr a_rd_err", 32'(a_rd_err), 0);
        chk("cr b_filled", 32'(b_filled), 1);
        chk("cr b_rd_err", 32'(b_rd_err), 1);
        clear_errs();
        read_both("cr bank0", 7'd7, 1, 775, 1, 775);

        // Out-of-range write
        wr_en = 1'b1; wr_addr = 7'd127; wr_data = DW'(12345);
        tick();
        wr_en = 1'b0;
        chk("oob wr a_wr_err", 32'(a_wr_err), 1);
        chk("oob wr b_wr_err", 32'(b_wr_err), 1);
        clear_errs();
        read_both("oob wr intact", 7'd7, 1, 775, 1, 775);

        // Reset during a read burst with two committed banks
        pulse_commit();
        chk("burst a_filled", 32'(a_filled), 2);
        chk("burst b_filled", 32'(b_filled), 2);
        rd_en = 1'b1; rd_addr = 7'd0;
        tick();
        rd_addr = 7'd1;
        tick();
        chk("burst a_vld", 32'(a_rd_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        rd_en = 1'b0;
        chk("arst a_vld", 32'(a_rd_valid), 0);
        chkd("arst a_data", a_rd_data, '0);
        chk("arst b_vld", 32'(b_rd_valid), 0);
        chkd("arst b_data", b_rd_data, '0);
        chk("arst filled", 32'({a_filled, b_filled}), 0);
        chk("arst ready", 32'({a_wr_ready, a_rd_ready, b_wr_ready, b_rd_ready}), 32'b1010);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-rst a_vld", 32'(a_rd_valid), 0);
            chk("post-rst b_vld", 32'(b_rd_valid), 0);
        end
        chk("post-rst errs", 32'({a_wr_err, a_rd_err, b_wr_err, b_rd_err}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
